mux3_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 3:1 mux datapath between three requesters (A=0, B=1, C=2).
It drives the mux select and a one-hot grant, and enforces a maximum hold time so no requester starves the others.
It sits directly in front of the 3-input mux and is its only source of `sel`.

---
 rtl/mux3_arb_pkg.sv | 41 ++++
 rtl/mux3_rr_arbiter_rr_pick3.sv | 64 ++++++
 rtl/mux3_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mux3_rr_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux3_arb_pkg.sv
// Shared definitions for the three-requester round-robin mux arbiter.
// Holds the mux select encodings, the arbiter state type and small
// index helpers used by both the picker and the top-level FSM.
package mux3_arb_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Requester index (0..2) to one-hot grant; the unused code 3 maps to none.
    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Modulo-3 successor of a requester index; code 3 folds back to A.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] nx;
        nx = 2'd0;
        case (idx)
            2'd0:    nx = 2'd1;
            2'd1:    nx = 2'd2;
            2'd2:    nx = 2'd0;
            default: nx = 2'd0;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// rr_pick3: combinational round-robin search over three requesters.
// Ports:
//   req[2:0]         request vector
//   start_idx[1:0]   first index examined; search wraps 0->1->2->0
//   exclude_en       when set, requester exclude_idx is ignored
//   exclude_idx[1:0] requester to skip (the current holder)
//   win_idx[1:0]     first asserted, non-excluded requester
//   win_valid        a winner exists
module rr_pick3
    import mux3_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] start_idx,
    input  logic       exclude_en,
    input  logic [1:0] exclude_idx,
    output logic [1:0] win_idx,
    output logic       win_valid
);

    logic [2:0] mask_s;
    logic [1:0] c0_s;
    logic [1:0] c1_s;
    logic [1:0] c2_s;

    // Mask the excluded requester and walk the three candidates in rotated order.
    always_comb begin
        mask_s    = 3'b000;
        c0_s      = 2'd0;
        c1_s      = 2'd0;
        c2_s      = 2'd0;
        win_idx   = 2'd0;
        win_valid = 1'b0;

        if (exclude_en) begin
            mask_s = req & ~idx_to_onehot(exclude_idx);
        end else begin
            mask_s = req;
        end

        // A start index of 3 cannot occur; fold it to A so indexing stays in range.
        if (start_idx == 2'd3) begin
            c0_s = 2'd0;
        end else begin
            c0_s = start_idx;
        end
        c1_s = next_idx(c0_s);
        c2_s = next_idx(c1_s);

        if (mask_s[c0_s]) begin
            win_idx   = c0_s;
            win_valid = 1'b1;
        end else if (mask_s[c1_s]) begin
            win_idx   = c1_s;
            win_valid = 1'b1;
        end else if (mask_s[c2_s]) begin
            win_idx   = c2_s;
            win_valid = 1'b1;
        end else begin
            win_idx   = 2'd0;
            win_valid = 1'b0;
        end
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: round-robin arbiter owning the select of a 3:1 mux,
// with a bounded hold time so a busy holder cannot starve the others.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   req[2:0]      request vector (A=0, B=1, C=2)
//   release_hold  holder is done; ignored while not busy. Named this way
//                 because "release" is a reserved word in SystemVerilog.
//   grant[2:0]    registered one-hot grant, 000 = none
//   sel[1:0]      registered mux select, holds its value while idle
//   busy          registered, equals |grant
//   preempt       one-cycle pulse when the grant was taken by hold timeout
module mux3_rr_arbiter
    import mux3_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       release_hold,
    output logic [2:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       preempt
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state_r,    state_nx_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_nx_s;
    logic [1:0]       last_ptr_r, last_ptr_nx_s;
    logic [2:0]       grant_r,    grant_nx_s;
    logic [1:0]       sel_r,      sel_nx_s;
    logic             busy_r,     busy_nx_s;
    logic             preempt_r,  preempt_nx_s;

    logic [1:0] win_idx_s;
    logic       win_valid_s;
    logic       others_pending_s;
    logic       exclude_en_s;
    logic       holder_req_s;
    logic       end_s;
    logic       timeout_s;

    // While granted, sel_r is the holder and last_ptr_r equals it, so starting
    // at last_ptr+1 with the holder excluded gives "everyone else in rr order".
    // With nobody else pending the exclusion is dropped, letting a holder that
    // releases and re-requests in the same cycle win again.
    always_comb begin
        others_pending_s = 1'b0;
        exclude_en_s     = 1'b0;
        holder_req_s     = 1'b0;
        if (state_r == GRANT) begin
            others_pending_s = |(req & ~grant_r);
            exclude_en_s     = others_pending_s;
            holder_req_s     = |(req & grant_r);
        end else begin
            others_pending_s = |req;
            exclude_en_s     = 1'b0;
            holder_req_s     = 1'b0;
        end
    end

    rr_pick3 u_pick (
        .req         (req),
        .start_idx   (next_idx(last_ptr_r)),
        .exclude_en  (exclude_en_s),
        .exclude_idx (sel_r),
        .win_idx     (win_idx_s),
        .win_valid   (win_valid_s)
    );

    // Next-state, counter and output decode for the IDLE/GRANT controller.
    always_comb begin
        state_nx_s    = state_r;
        hold_cnt_nx_s = hold_cnt_r;
        last_ptr_nx_s = last_ptr_r;
        grant_nx_s    = grant_r;
        sel_nx_s      = sel_r;
        busy_nx_s     = busy_r;
        preempt_nx_s  = 1'b0;
        end_s         = 1'b0;
        timeout_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    state_nx_s    = GRANT;
                    grant_nx_s    = idx_to_onehot(win_idx_s);
                    sel_nx_s      = win_idx_s;
                    busy_nx_s     = 1'b1;
                    hold_cnt_nx_s = '0;
                    last_ptr_nx_s = win_idx_s;
                end else begin
                    state_nx_s    = IDLE;
                end
            end
            GRANT: begin
                end_s = release_hold | ~holder_req_s;
                // >= catches a requester arriving after the counter saturated.
                timeout_s = ~end_s & (hold_cnt_r >= HOLD_LIM) & others_pending_s;
                if (end_s) begin
                    if (win_valid_s) begin
                        grant_nx_s    = idx_to_onehot(win_idx_s);
                        sel_nx_s      = win_idx_s;
                        busy_nx_s     = 1'b1;
                        hold_cnt_nx_s = '0;
                        last_ptr_nx_s = win_idx_s;
                    end else begin
                        state_nx_s    = IDLE;
                        grant_nx_s    = 3'b000;
                        busy_nx_s     = 1'b0;
                        hold_cnt_nx_s = '0;
                    end
                end else if (timeout_s) begin
                    grant_nx_s    = idx_to_onehot(win_idx_s);
                    sel_nx_s      = win_idx_s;
                    busy_nx_s     = 1'b1;
                    hold_cnt_nx_s = '0;
                    last_ptr_nx_s = win_idx_s;
                    preempt_nx_s  = 1'b1;
                end else if (hold_cnt_r < HOLD_SAT) begin
                    hold_cnt_nx_s = hold_cnt_r + CNT_ONE;
                end else begin
                    hold_cnt_nx_s = hold_cnt_r;
                end
            end
            default: begin
                state_nx_s    = IDLE;
                grant_nx_s    = 3'b000;
                busy_nx_s     = 1'b0;
                hold_cnt_nx_s = '0;
            end
        endcase
    end

    // State, counter, rr pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            hold_cnt_r <= '0;
            last_ptr_r <= 2'd2;
            grant_r    <= 3'b000;
            sel_r      <= SEL_A;
            busy_r     <= 1'b0;
            preempt_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            hold_cnt_r <= hold_cnt_nx_s;
            last_ptr_r <= last_ptr_nx_s;
            grant_r    <= grant_nx_s;
            sel_r      <= sel_nx_s;
            busy_r     <= busy_nx_s;
            preempt_r  <= preempt_nx_s;
        end
    end

    assign grant   = grant_r;
    assign sel     = sel_r;
    assign busy    = busy_r;
    assign preempt = preempt_r;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
module tb_mux3_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int WAIT_BOUND = 2 * MAX_HOLD + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       release_hold = 1'b0;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    // Model state: holder index (-1 = none), rr pointer, hold age, outputs.
    int m_holder = -1;
    int m_last   = 2;
    int m_cnt    = 0;
    int m_sel    = 0;
    bit m_preempt = 1'b0;

    int wait_cnt [3];
    int max_wait = 0;

    mux3_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .release_hold (release_hold),
        .grant        (grant),
        .sel          (sel),
        .busy         (busy),
        .preempt      (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int start, input int excl);
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (start + k) % 3;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    // Behavioural model: who should own the mux after this edge.
    always @(posedge clk) begin : model_p
        int nh, nl, nc, ns, o, h;
        bit np, ending, tmo;
        nh = m_holder; nl = m_last; nc = m_cnt; ns = m_sel; np = 1'b0;
        if (rst) begin
            nh = -1; nl = 2; nc = 0; ns = 0;
        end else if (m_holder < 0) begin
            o = pick(req, (m_last + 1) % 3, -1);
            if (o >= 0) begin nh = o; nl = o; nc = 0; ns = o; end
        end else begin
            h = m_holder;
            o = pick(req, (h + 1) % 3, h);
            ending = release_hold || !req[h];
            tmo = !ending && (m_cnt >= MAX_HOLD - 1) && (o >= 0);
            if (ending) begin
                if (o >= 0) begin nh = o; nl = o; nc = 0; ns = o; end
                else if (req[h]) begin nh = h; nl = h; nc = 0; ns = h; end
                else begin nh = -1; nc = 0; end
            end else if (tmo) begin
                nh = o; nl = o; nc = 0; ns = o; np = 1'b1;
            end else if (m_cnt < MAX_HOLD) begin
                nc = m_cnt + 1;
            end
        end
        m_holder  <= nh;
        m_last    <= nl;
        m_cnt     <= nc;
        m_sel     <= ns;
        m_preempt <= np;
    end

    // Per-cycle comparison of the DUT against the model, plus starvation tracking.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_grant", {29'd0, grant}, (m_holder < 0) ? 32'd0 : (32'd1 << m_holder));
            check("model_sel", {30'd0, sel}, m_sel);
            check("model_busy", {31'd0, busy}, {31'd0, (m_holder >= 0)});
            check("model_preempt", {31'd0, preempt}, {31'd0, m_preempt});
            for (int i = 0; i < 3; i++) begin
                if (req[i] && !grant[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 3'b000; release_hold = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;

        // Reset state.
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_grant", {29'd0, grant}, 32'h0);
        check("rst_sel", {30'd0, sel}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_preempt", {31'd0, preempt}, 32'h0);

        // Single requester, then release.
        rst = 1'b0; req = 3'b001;
        tick();
        check("s1_grant", {29'd0, grant}, 32'h1);
        check("s1_sel", {30'd0, sel}, 32'h0);
        tick(); tick();
        req = 3'b000; release_hold = 1'b1;
        tick();
        release_hold = 1'b0;
        check("s1_rel_grant", {29'd0, grant}, 32'h0);
        check("s1_rel_busy", {31'd0, busy}, 32'h0);
        check("s1_idle_sel", {30'd0, sel}, 32'h0);

        // All request, release every second cycle: A,B,C,A.
        do_reset();
        req = 3'b111;
        tick();
        check("rr_a", {29'd0, grant}, 32'h1);
        release_hold = 1'b1; tick(); release_hold = 1'b0;
        check("rr_b", {29'd0, grant}, 32'h2);
        check("rr_b_sel", {30'd0, sel}, 32'h1);
        tick();
        release_hold = 1'b1; tick(); release_hold = 1'b0;
        check("rr_c", {29'd0, grant}, 32'h4);
        check("rr_c_sel", {30'd0, sel}, 32'h2);
        tick();
        release_hold = 1'b1; tick(); release_hold = 1'b0;
        check("rr_a2", {29'd0, grant}, 32'h1);
        check("rr_a2_sel", {30'd0, sel}, 32'h0);

        // Hold timeout ping-pong between A and B.
        do_reset();
        req = 3'b011;
        tick();
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            check("to_a_hold", {29'd0, grant}, 32'h1);
        end
        tick();
        check("to_b_grant", {29'd0, grant}, 32'h2);
        check("to_b_preempt", {31'd0, preempt}, 32'h1);
        tick();
        check("to_pulse_end", {31'd0, preempt}, 32'h0);
        for (int i = 2; i < MAX_HOLD; i++) tick();
        tick();
        check("to_back_a", {29'd0, grant}, 32'h1);
        check("to_back_a_pre", {31'd0, preempt}, 32'h1);

        // Lone holder saturates, late arrival preempts on the next edge.
        do_reset();
        req = 3'b001;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("sat_pre", {31'd0, preempt}, 32'h0);
        end
        check("sat_grant", {29'd0, grant}, 32'h1);
        req = 3'b011;
        tick();
        check("late_grant", {29'd0, grant}, 32'h2);
        check("late_pre", {31'd0, preempt}, 32'h1);

        // Reset while C holds.
        do_reset();
        req = 3'b100;
        tick(); tick();
        check("c_hold", {30'd0, sel}, 32'h2);
        rst = 1'b1;
        tick();
        check("midrst_grant", {29'd0, grant}, 32'h0);
        check("midrst_sel", {30'd0, sel}, 32'h0);
        rst = 1'b0; req = 3'b111;
        tick();
        check("midrst_a_first", {29'd0, grant}, 32'h1);

        // Random traffic with sticky requests.
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
        max_wait = 0;
        for (int c = 0; c < 10000; c++) begin
            logic [2:0] r;
            for (int i = 0; i < 3; i++) begin
                if (req[i] && !grant[i]) r[i] = 1'b1;
                else r[i] = ($urandom_range(0, 3) != 0);
            end
            req = r;
            release_hold = ($urandom_range(0, 5) == 0);
            tick();
        end
        check("max_wait_ok", {31'd0, (max_wait <= WAIT_BOUND)}, 32'h1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
